// File: rtl/alu_pkg.sv
// Shared opcodes, handshake state encoding and op classification for alu_iter.
// ALU_ITER_DIV_EN selects whether DIV is a multi-cycle op.
package alu_pkg;

   localparam logic [3:0] OP_SLTU = 4'b0000;
   localparam logic [3:0] OP_SRA  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOTA = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1010;
   localparam logic [3:0] OP_SUBU = 4'b1011;
   localparam logic [3:0] OP_ADDU = 4'b1100;
   localparam logic [3:0] OP_SLT  = 4'b1101;
   localparam logic [3:0] OP_MUL  = 4'b1110;
   localparam logic [3:0] OP_DIV  = 4'b1111;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_ITER_DIV_EN
      return (op == OP_MUL) || (op == OP_DIV);
`else
      return (op == OP_MUL);
`endif
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative engine: shift-add multiplier (low half) and, with ALU_ITER_DIV_EN,
// a restoring divider sharing the same three working registers.
module alu_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
`ifdef ALU_ITER_DIV_EN
   input  logic             i_op_div,
`endif
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_result
`ifdef ALU_ITER_DIV_EN
   ,
   output logic [WIDTH-1:0] o_rem
`endif
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   // r_acc: product accumulator / partial remainder
   // r_x:   multiplier shifting right / dividend shifting into quotient
   // r_y:   multiplicand shifting left / fixed divisor
   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] w_acc_nx;
   logic [WIDTH-1:0] w_x_nx;
   logic [WIDTH-1:0] w_y_nx;

`ifdef ALU_ITER_DIV_EN
   logic             r_is_div;
   logic [WIDTH:0]   w_shift;
   logic             w_fits;
   logic [WIDTH-1:0] w_sub;

   assign w_shift = {r_acc, r_x[WIDTH-1]};
   assign w_fits  = (w_shift >= {1'b0, r_y});
   assign w_sub   = w_shift[WIDTH-1:0] - r_y;
`endif

   always_comb begin
      w_acc_nx = r_x[0] ? (r_acc + r_y) : r_acc;
      w_x_nx   = r_x >> 1;
      w_y_nx   = r_y << 1;
`ifdef ALU_ITER_DIV_EN
      if (r_is_div) begin
         w_acc_nx = w_fits ? w_sub : w_shift[WIDTH-1:0];
         w_x_nx   = {r_x[WIDTH-2:0], w_fits};
         w_y_nx   = r_y;
      end
`endif
   end

   // The final step's next-state values are the answer; the top registers
   // them on the same edge so the result appears WIDTH+1 cycles after start.
   assign o_last = r_busy && (r_cnt == CNT_W'(1));
`ifdef ALU_ITER_DIV_EN
   assign o_result = r_is_div ? w_x_nx : w_acc_nx;
   assign o_rem    = r_is_div ? w_acc_nx : '0;
`else
   assign o_result = w_acc_nx;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_x    <= '0;
         r_y    <= '0;
`ifdef ALU_ITER_DIV_EN
         r_is_div <= 1'b0;
`endif
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= CNT_W'(WIDTH);
         r_acc  <= '0;
         r_x    <= i_a;
         r_y    <= i_b;
`ifdef ALU_ITER_DIV_EN
         r_is_div <= i_op_div;
`endif
      end else if (r_busy) begin
         r_acc <= w_acc_nx;
         r_x   <= w_x_nx;
         r_y   <= w_y_nx;
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle ops registered in one cycle, MUL (and DIV when
// ALU_ITER_DIV_EN is defined) run on alu_muldiv_seq for WIDTH cycles.
module alu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 10,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  operand_A,
   input  logic [WIDTH-1:0]  operand_B,
   input  logic [3:0]        alu_control,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  alu_result,
   output logic [WIDTH-1:0]  alu_remainder,
   output logic              zero_flag,
   output logic              overflow,
   output logic              div_by_zero,
   output logic [ADDR_W-1:0] ram_address
);

   state_t                   r_state;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic [WIDTH-1:0]         r_result;
   logic                     r_zero;
   logic                     r_ovf;

   logic signed [WIDTH-1:0]  w_a_s;
   logic signed [WIDTH-1:0]  w_b_s;
   logic [SHAMT_W-1:0]       w_shamt;
   logic [WIDTH-1:0]         w_sum;
   logic [WIDTH-1:0]         w_dif;
   logic [WIDTH-1:0]         w_res;
   logic                     w_ovf;
   logic                     w_div_zero;
   logic                     w_start;
   logic                     w_eng_last;
   logic [WIDTH-1:0]         w_eng_res;

   assign w_a_s   = operand_A;
   assign w_b_s   = operand_B;
   assign w_shamt = operand_B[SHAMT_W-1:0];
   assign w_sum   = operand_A + operand_B;
   assign w_dif   = operand_A - operand_B;

`ifdef ALU_ITER_DIV_EN
   logic [WIDTH-1:0]         r_rem;
   logic                     r_dbz;
   logic [WIDTH-1:0]         w_eng_rem;

   assign w_div_zero = (alu_control == OP_DIV) && (operand_B == '0);
`else
   assign w_div_zero = 1'b0;
`endif

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (alu_control)
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (operand_A < operand_B)};
         OP_SRA:  w_res = w_a_s >>> w_shamt;
         OP_ADD: begin
            w_res = w_sum;
            w_ovf = (operand_A[WIDTH-1] == operand_B[WIDTH-1]) && (w_sum[WIDTH-1] != operand_A[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_dif;
            w_ovf = (operand_A[WIDTH-1] != operand_B[WIDTH-1]) && (w_dif[WIDTH-1] != operand_A[WIDTH-1]);
         end
         OP_AND:  w_res = operand_A & operand_B;
         OP_OR:   w_res = operand_A | operand_B;
         OP_XOR:  w_res = operand_A ^ operand_B;
         OP_NOTA: w_res = ~operand_A;
         OP_SLL:  w_res = operand_A << w_shamt;
         OP_SRL:  w_res = operand_A >> w_shamt;
         OP_NOR:  w_res = ~(operand_A | operand_B);
         OP_SUBU: w_res = w_dif;
         OP_ADDU: w_res = w_sum;
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
         // Only the divide-by-zero quotient comes from here; MUL/DIV otherwise use the engine.
         OP_DIV:  w_res = w_div_zero ? '1 : '0;
         default: w_res = '0;
      endcase
   end

   assign w_start = (r_state == IDLE) && in_valid && is_multicycle(alu_control) && !w_div_zero;

   alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_start  (w_start),
`ifdef ALU_ITER_DIV_EN
      .i_op_div (alu_control == OP_DIV),
`endif
      .i_a      (operand_A),
      .i_b      (operand_B),
      .o_last   (w_eng_last),
      .o_result (w_eng_res)
`ifdef ALU_ITER_DIV_EN
      ,
      .o_rem    (w_eng_rem)
`endif
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
`ifdef ALU_ITER_DIV_EN
         r_rem       <= '0;
         r_dbz       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  if (w_start) begin
                     r_state  <= CALC;
                     r_result <= '0;
                     r_zero   <= 1'b0;
                     r_ovf    <= 1'b0;
`ifdef ALU_ITER_DIV_EN
                     r_rem    <= '0;
                     r_dbz    <= 1'b0;
`endif
                  end else begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                     r_result    <= w_res;
                     r_zero      <= (w_res == '0);
                     r_ovf       <= w_ovf;
`ifdef ALU_ITER_DIV_EN
                     r_rem       <= w_div_zero ? operand_A : '0;
                     r_dbz       <= w_div_zero;
`endif
                  end
               end
            end
            CALC: begin
               if (w_eng_last) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_eng_res;
                  r_zero      <= (w_eng_res == '0);
`ifdef ALU_ITER_DIV_EN
                  r_rem       <= w_eng_rem;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign alu_result  = r_result;
   assign zero_flag   = r_zero;
   assign overflow    = r_ovf;
   assign ram_address = r_result[ADDR_W-1:0];
`ifdef ALU_ITER_DIV_EN
   assign alu_remainder = r_rem;
   assign div_by_zero   = r_dbz;
`else
   assign alu_remainder = '0;
   assign div_by_zero   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: directed corner ops, reset abort, then random ops.
module tb_alu_iter;

   localparam int W  = 32;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  operand_A = '0;
   logic [W-1:0]  operand_B = '0;
   logic [3:0]    alu_control = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  alu_result;
   logic [W-1:0]  alu_remainder;
   logic          zero_flag;
   logic          overflow;
   logic          div_by_zero;
   logic [AW-1:0] ram_address;

   alu_iter #(.WIDTH(W), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .operand_A(operand_A), .operand_B(operand_B), .alu_control(alu_control),
      .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
      .alu_remainder(alu_remainder), .zero_flag(zero_flag), .overflow(overflow),
      .div_by_zero(div_by_zero), .ram_address(ram_address)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] res;
      logic [W-1:0] rem;
      logic         zero;
      logic         ovf;
      logic         dbz;
      int           lat;
      int           acc;
      int           hold;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa, sb_, s;
      int     sh;
      logic [63:0] prod;
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      sh = int'(b[4:0]);
      e.op = op; e.rem = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.lat = 1; e.acc = 0; e.hold = 0;
      case (op)
         4'h0: e.res = (a < b) ? 1 : 0;
         4'h1: e.res = W'(sa >>> sh);
         4'h2: begin s = sa + sb_; e.res = a + b; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h3: begin s = sa - sb_; e.res = a - b; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h4: e.res = a & b;
         4'h5: e.res = a | b;
         4'h6: e.res = a ^ b;
         4'h7: e.res = ~a;
         4'h8: e.res = a << sh;
         4'h9: e.res = a >> sh;
         4'hA: e.res = ~(a | b);
         4'hB: e.res = a - b;
         4'hC: e.res = a + b;
         4'hD: e.res = (sa < sb_) ? 1 : 0;
         4'hE: begin prod = 64'(a) * 64'(b); e.res = prod[W-1:0]; e.lat = W + 1; end
         default: begin
`ifdef ALU_ITER_DIV_EN
            if (b == 0) begin e.res = '1; e.rem = a; e.dbz = 1'b1; end
            else begin e.res = a / b; e.rem = a % b; e.lat = W + 1; end
`else
            e.res = '0;
`endif
         end
      endcase
      e.zero = (e.res == 0);
      return e;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      exp_t e;
      bit   ok;
      e = model(op, a, b);
      e.hold = hold;
      @(negedge clk);
      in_valid = 1'b1; alu_control = op; operand_A = a; operand_B = b;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL accept_timeout op%0h: got in_ready=0 for 200 cycles, expected 1", op);
         in_valid = 1'b0;
         return;
      end
      e.acc = cyc;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      operand_A = $urandom; operand_B = $urandom; alu_control = 4'($urandom);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: consumer side, pops and compares on the first valid cycle, then
   // checks the held outputs stay frozen until it accepts.
   logic         seen = 1'b0;
   int           hold_left = 0;
   exp_t         cur;
   logic [W-1:0] s_res, s_rem;
   logic [2:0]   s_flg;

   always @(negedge clk) begin
      if (!reset_n) begin
         seen = 1'b0;
         out_ready = 1'b0;
      end else if (out_valid) begin
         chk("in_ready_low_in_done", in_ready, 0);
         if (!seen) begin
            if (sb.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL unexpected_output: got out_valid=1, expected no pending op");
               hold_left = 0;
            end else begin
               cur = sb.pop_front();
               chk($sformatf("result_op%0h", cur.op), alu_result, cur.res);
               chk($sformatf("remainder_op%0h", cur.op), alu_remainder, cur.rem);
               chk($sformatf("zero_op%0h", cur.op), zero_flag, cur.zero);
               chk($sformatf("overflow_op%0h", cur.op), overflow, cur.ovf);
               chk($sformatf("div_by_zero_op%0h", cur.op), div_by_zero, cur.dbz);
               chk($sformatf("ram_address_op%0h", cur.op), ram_address, cur.res[AW-1:0]);
               chk($sformatf("latency_op%0h", cur.op), cyc - cur.acc, cur.lat);
               hold_left = cur.hold;
            end
            s_res = alu_result; s_rem = alu_remainder; s_flg = {zero_flag, overflow, div_by_zero};
            seen = 1'b1;
         end else begin
            chk("hold_result", alu_result, s_res);
            chk("hold_remainder", alu_remainder, s_rem);
            chk("hold_flags", {zero_flag, overflow, div_by_zero}, s_flg);
         end
         out_ready = (hold_left == 0);
         if (hold_left > 0) hold_left--;
         if (out_ready) seen = 1'b0;
      end else begin
         out_ready = 1'b0;
      end
   end

   initial begin
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", alu_result, 0);
      chk("reset_flags", {zero_flag, overflow, div_by_zero}, 0);
      reset_n = 1'b1;

      issue(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 0);
      issue(4'hC, 32'h7FFF_FFFF, 32'h0000_0001, 1);
      issue(4'h3, 32'h8000_0000, 32'h0000_0001, 0);
      issue(4'h3, 32'd5, 32'd5, 0);
      issue(4'hD, 32'hFFFF_FFFF, 32'd1, 0);
      issue(4'h0, 32'hFFFF_FFFF, 32'd1, 0);
      issue(4'h1, 32'h8000_0000, 32'h0000_0021, 0);
      issue(4'h9, 32'h8000_0000, 32'h0000_0021, 0);
      issue(4'h8, 32'd1, 32'd31, 2);
      issue(4'hE, 32'h0001_0003, 32'h0000_0005, 3);
`ifdef ALU_ITER_DIV_EN
      issue(4'hF, 32'd100, 32'd7, 1);
      issue(4'hF, 32'd9, 32'd0, 0);
`else
      issue(4'hF, 32'd100, 32'd7, 0);
`endif

      // Reset in the middle of a multiply must abandon it cleanly.
      issue(4'hE, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_result", alu_result, 0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      issue(4'h2, 32'd2, 32'd3, 0);

      for (int n = 0; n < 80; n++) begin
         logic [W-1:0] ra, rb;
         ra = pick();
         rb = pick();
         issue(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2));
      end

      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0 && !seen) break;
         @(negedge clk);
      end
      if (sb.size() != 0 || seen) begin
         n_cmp++; n_fail++;
         $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised successor to the single-cycle CPU ALU, with width set by a parameter.
- Computes all existing ALU opcodes with registered results and correct signed overflow.
- Adds SRA, SLTU, and an iterative shift-add multiplier and restoring divider controlled by a state machine.
- Sits between the register file/decoder and writeback/RAM; a valid/ready handshake on both sides lets multi-cycle ops stall the core.

Parameters:
- WIDTH, 32, operand and result width (≥8, power of 2).
- ADDR_W, 10, width of ram_address (≤WIDTH).
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from operand_B.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an op
- operand_A  in  WIDTH  first operand
- operand_B  in  WIDTH  second operand / shift amount
- alu_control  in  4  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- alu_result  out  WIDTH  result (MUL: low WIDTH bits; DIV: quotient)
- alu_remainder  out  WIDTH  DIV remainder, else 0
- zero_flag  out  1  alu_result == 0
- overflow  out  1  signed overflow (ADD/SUB only)
- div_by_zero  out  1  DIV with operand_B == 0
- ram_address  out  ADDR_W  alu_result[ADDR_W-1:0]

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0; all data/flag outputs 0.
- Accept: an op is accepted when in_valid && in_ready. Operands are captured at acceptance; later input changes are ignored.
- Opcodes:
  - 0000 SLTU
  - 0001 SRA
  - 0010 ADD
  - 0011 SUB
  - 0100 AND
  - 0101 OR
  - 0110 XOR
  - 0111 NOT A
  - 1000 SLL
  - 1001 SRL
  - 1010 NOR
  - 1011 SUBU
  - 1100 ADDU
  - 1101 SLT (signed)
  - 1110 MUL (unsigned, low half)
  - 1111 DIV (unsigned)
- Arithmetic rules:
  - SUB/SUBU are plain two's-complement A-B.
  - ADD/ADDU are A+B, mod 2^WIDTH.
  - Shifts use operand_B[SHAMT_W-1:0] only.
- Overflow:
  - ADD: overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB: overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - All other ops: 0.
  - The result is always written, even on overflow (no trap).
- Single-cycle ops (all except MUL/DIV):
  - IDLE --accept--> DONE.
  - out_valid=1 on the cycle after acceptance (latency 1).
- MUL/DIV:
  - IDLE --accept--> CALC. Counter loads WIDTH, one bit is processed per cycle, counter decrements.
  - At count==0 → DONE. out_valid is asserted WIDTH+1 cycles after acceptance.
  - in_ready=0 in CALC and in DONE.
- DONE:
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready → IDLE, out_valid=0 next cycle.
  - No accept occurs in the same cycle as out_ready handshake; throughput for single-cycle ops is 1 op / 2 cycles.
- Divide by zero: no iteration; DONE on the next cycle with quotient=all-ones, remainder=A, div_by_zero=1.
- Flag qualification: zero_flag, overflow and div_by_zero are valid only with out_valid and are cleared on the next accept.
- Undefined behaviour: none. Every 4-bit opcode is defined.
- Reset mid-CALC: aborts immediately, all outputs 0, state IDLE.

Optional Feature:
- Macro: ALU_ITER_DIV_EN.
- Defined: DIV is implemented as above.
- Undefined:
  - Divider logic and alu_remainder datapath are not built; alu_remainder is tied 0 and div_by_zero is tied 0.
  - Opcode 1111 completes single-cycle with alu_result=0 and zero_flag=1.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD, OP_SUB, …, OP_DIV);
  - state enum {IDLE, CALC, DONE};
  - helper function is_multicycle(op).
- Sub-module alu_muldiv_seq: iterative shift-add/restoring engine with start, op_div, done, product/quotient and remainder outputs. The top holds the handshake FSM and the combinational single-cycle datapath.

Test Plan:
- ADD overflow (WIDTH=32): ADD 0x7FFFFFFF + 0x00000001 → out_valid 1 cycle later; result 0x80000000, overflow=1, zero_flag=0. ADDU with the same operands → overflow=0.
- SUB zero and sign: SUB 0x80000000 - 0x00000001 → 0x7FFFFFFF, overflow=1. SUB 5-5 → 0, zero_flag=1. SLT 0xFFFFFFFF,1 → 1; SLTU → 0.
- Shifts: SRA 0x80000000 by B=0x00000021 (shamt 1) → 0xC0000000. SRL → 0x40000000. SLL 1 by 31 → 0x80000000.
- MUL timing: MUL 0x0001_0003 × 0x0000_0005 → in_ready low, out_valid exactly 33 cycles after accept, result 0x0005_000F. Hold out_ready=0 for 3 cycles → outputs stable.
- DIV (macro on): DIV 100/7 → quotient 14, remainder 2 after 33 cycles. DIV 9/0 → next cycle quotient 0xFFFFFFFF, remainder 9, div_by_zero=1.
- Reset abort: deassert reset_n 10 cycles into MUL → out_valid=0, in_ready=1 after release, next ADD 2+3 → 5 with latency 1.
